mp64_sram_arb: RTL and testbench

Two-requester round-robin arbiter that shares one `mp64_sram_sp` instance between two masters, such as a CPU data port and a DMA engine. It owns the SRAM's `ce`/`we`/`addr`/`wdata` pins. It tracks in-flight reads through a tag pipeline matched to the SRAM read latency, so each master gets its own read-valid strobe. It sits directly above the SRAM macro wrapper; all other logic accesses the SRAM only through it.

---
 rtl/mp64_sram_pkg.sv | 9 +
 rtl/mp64_sram_tagpipe.sv | 24 ++
 rtl/mp64_sram_arb.sv | 59 +++++
 tb/tb_mp64_sram_arb.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/mp64_sram_pkg.sv
// mp64_sram_pkg: shared tag entry type and owner encodings for the SRAM arbiter
package mp64_sram_pkg;
  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;
  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;
endpackage

// File: rtl/mp64_sram_tagpipe.sv
// mp64_sram_tagpipe: read tag shift register matched to SRAM latency, decodes per-master rvalid
module mp64_sram_tagpipe
  import mp64_sram_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t tag_i,
  output logic a_rvalid_o,
  output logic b_rvalid_o
);
  tag_t pipe_q [RD_LAT];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end
  assign a_rvalid_o = pipe_q[RD_LAT-1].valid & (pipe_q[RD_LAT-1].owner == OWN_A);
  assign b_rvalid_o = pipe_q[RD_LAT-1].valid & (pipe_q[RD_LAT-1].owner == OWN_B);
endmodule

// File: rtl/mp64_sram_arb.sv
// mp64_sram_arb: two-master round-robin arbiter owning a single-port SRAM, with per-master read strobes
module mp64_sram_arb
  import mp64_sram_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 64,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $error("mp64_sram_arb: RD_LAT must be 1 or 2");
  end
  logic pri_q, pri_d;
  tag_t tag;
  always_comb begin
    a_gnt      = a_req & (~b_req | ~pri_q);
    b_gnt      = b_req & (~a_req | pri_q);
    sram_ce    = rst_n & (a_gnt | b_gnt);
    sram_we    = a_gnt ? a_we : b_gnt ? b_we : 1'b0;
    sram_addr  = a_gnt ? a_addr : b_gnt ? b_addr : '0;
    sram_wdata = a_gnt ? a_wdata : b_gnt ? b_wdata : '0;
    pri_d      = a_gnt ? OWN_B : b_gnt ? OWN_A : pri_q;
    tag        = '{valid: sram_ce & ~sram_we, owner: b_gnt};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pri_q <= 1'b0;
    else pri_q <= pri_d;
  end
  mp64_sram_tagpipe #(.RD_LAT(RD_LAT)) u_tagpipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .tag_i     (tag),
    .a_rvalid_o(a_rvalid),
    .b_rvalid_o(b_rvalid)
  );
  assign a_rdata = sram_rdata;
  assign b_rdata = sram_rdata;
endmodule

// File: tb/tb_mp64_sram_arb.sv
// tb_mp64_sram_arb: scoreboard bench driving RD_LAT=1 and RD_LAT=2 arbiters with shared stimulus
module tb_mp64_sram_arb;
  logic clk = 0, rst_n = 0;
  logic a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [3:0] a_addr = 0, b_addr = 0;
  logic [63:0] a_wdata = 0, b_wdata = 0;
  logic ag1, av1, bg1, bv1, ce1, we1, ag2, av2, bg2, bv2, ce2, we2;
  logic [3:0] ad1, ad2;
  logic [63:0] ar1, br1, ar2, br2, wd1, wd2, rd1, rd2, r2a;
  logic [63:0] mem1 [16];
  logic [63:0] mem2 [16];
  int n_chk = 0, n_fail = 0, cyc = 0, h1 = 0, h2 = 0;
  typedef struct {logic own; int gc; logic [63:0] d;} exp_t;
  exp_t q[$];
  logic [63:0] mmem [16];
  logic mpri = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mp64_sram_arb #(.ADDR_W(4), .DATA_W(64), .RD_LAT(1)) u_l1 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(ag1), .a_rvalid(av1), .a_rdata(ar1),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(bg1), .b_rvalid(bv1), .b_rdata(br1),
    .sram_ce(ce1), .sram_we(we1), .sram_addr(ad1), .sram_wdata(wd1), .sram_rdata(rd1));
  mp64_sram_arb #(.ADDR_W(4), .DATA_W(64), .RD_LAT(2)) u_l2 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(ag2), .a_rvalid(av2), .a_rdata(ar2),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(bg2), .b_rvalid(bv2), .b_rdata(br2),
    .sram_ce(ce2), .sram_we(we2), .sram_addr(ad2), .sram_wdata(wd2), .sram_rdata(rd2));

  // Single-port SRAM models: OUT_REG=0 for the first instance, OUT_REG=1 for the second
  always @(posedge clk) begin
    if (ce1 && we1) mem1[ad1] <= wd1;
    if (ce1 && !we1) rd1 <= mem1[ad1];
    if (ce2 && we2) mem2[ad2] <= wd2;
    if (ce2 && !we2) r2a <= mem2[ad2];
    rd2 <= r2a;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic chk_rd(input int lat, inout int h, input logic av, input logic bv,
                        input logic [63:0] rd, input logic [63:0] brd);
    logic v;
    exp_t e;
    v = (h < q.size()) && (q[h].gc + lat == cyc);
    e = v ? q[h] : '{own: 1'b0, gc: 0, d: 64'd0};
    chk($sformatf("a_rvalid_L%0d", lat), {63'd0, av}, {63'd0, v && !e.own});
    chk($sformatf("b_rvalid_L%0d", lat), {63'd0, bv}, {63'd0, v && e.own});
    if (v) begin
      chk($sformatf("rdata_L%0d", lat), e.own ? brd : rd, e.d);
      h++;
    end
  endtask

  always @(negedge clk) begin
    logic ga, gb;
    if (!rst_n) begin
      chk("ce_in_reset_L1", {63'd0, ce1}, 64'd0);
      chk("ce_in_reset_L2", {63'd0, ce2}, 64'd0);
      chk("rvalid_in_reset", {60'd0, av1, bv1, av2, bv2}, 64'd0);
      h1 = q.size();
      h2 = q.size();
      mpri = 1'b0;
    end else begin
      ga = a_req && (!b_req || !mpri);
      gb = b_req && (!a_req || mpri);
      chk("gnt_L1", {62'd0, ag1, bg1}, {62'd0, ga, gb});
      chk("gnt_L2", {62'd0, ag2, bg2}, {62'd0, ga, gb});
      chk("ce", {62'd0, ce1, ce2}, {62'd0, ga || gb, ga || gb});
      chk("we", {62'd0, we1, we2}, {62'd0, ga ? a_we : gb && b_we, ga ? a_we : gb && b_we});
      chk("addr", {56'd0, ad1, ad2}, {56'd0, ga ? a_addr : gb ? b_addr : 4'd0, ga ? a_addr : gb ? b_addr : 4'd0});
      chk("wdata_L1", wd1, ga ? a_wdata : gb ? b_wdata : 64'd0);
      chk("wdata_L2", wd2, ga ? a_wdata : gb ? b_wdata : 64'd0);
      chk_rd(1, h1, av1, bv1, ar1, br1);
      chk_rd(2, h2, av2, bv2, ar2, br2);
      if (ga || gb) begin
        if (ga ? a_we : b_we) mmem[ga ? a_addr : b_addr] = ga ? a_wdata : b_wdata;
        else q.push_back('{own: gb, gc: cyc, d: mmem[ga ? a_addr : b_addr]});
      end
      mpri = ga ? 1'b1 : gb ? 1'b0 : mpri;
    end
  end

  task automatic step(input logic ar, input logic aw, input logic [3:0] aa, input logic [63:0] ad,
                      input logic br, input logic bw, input logic [3:0] ba, input logic [63:0] bd);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    // contention from reset: both masters write, grants must alternate A,B,A,B
    for (int i = 0; i < 8; i++) step(1, 1, 4'd14, 64'h11, 1, 1, 4'd15, 64'h22);
    idle(2);
    // single-master fill then read-back
    for (int i = 0; i < 16; i++) step(1, 1, 4'(i), 64'hA000_0000_0000_0000 + 64'(i), 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(1, 0, 4'(i), 0, 0, 0, 0, 0);
    idle(3);
    chk("fill_readback_a5", mmem[5], 64'hA000_0000_0000_0005);
    // interleaved reads after B's write
    step(0, 0, 0, 0, 1, 1, 4'd5, 64'hDEAD_BEEF_CAFE_BABE);
    step(1, 0, 4'd5, 0, 1, 0, 4'd3, 0);
    step(0, 0, 0, 0, 1, 0, 4'd3, 0);
    idle(3);
    // idle hold after B grant, then simultaneous request must favour A
    step(0, 0, 0, 0, 1, 0, 4'd2, 0);
    idle(5);
    step(1, 0, 4'd1, 0, 1, 0, 4'd2, 0);
    step(0, 0, 0, 0, 1, 0, 4'd2, 0);
    idle(3);
    // write then immediate read by the other master
    step(1, 1, 4'd7, 64'h1234, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 4'd7, 0);
    idle(3);
    chk("wr_then_rd_model", mmem[7], 64'h1234);
    // reset pulsed shortly after a read grant: no rvalid may follow
    step(1, 0, 4'd4, 0, 0, 0, 0, 0);
    #1 rst_n = 0;
    a_req = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    step(1, 0, 4'd2, 0, 1, 0, 4'd3, 0);
    step(0, 0, 0, 0, 1, 0, 4'd3, 0);
    idle(4);
    chk("drain_L1", 64'(h1), 64'(q.size()));
    chk("drain_L2", 64'(h2), 64'(q.size()));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
